id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//   ID/EX pipeline register feeding the ALU. Latches decoded operands and control from decode,
//   then forwards EX/MEM or MEM/WB results into operand1/operand2 to resolve RAW hazards.
//   Detects load-use hazards, stalls IF/ID and inserts a bubble. Branch flush kills the entry.
// PARAMETERS
//   DATA_W      32  datapath width (ALU operand / result width)
//   REG_AW      5   register-file address width
//   STALL_CW    16  width of saturating load-use stall counter
// PORTS
//   clk            in   1         rising-edge clock
//   rst            in   1         asynchronous, active-high reset
//   id_valid       in   1         decode slot holds a real instruction
//   id_rs, id_rt   in   REG_AW    source register numbers
//   id_rd          in   REG_AW    destination register number (already muxed rt/rd)
//   id_rdata1/2    in   DATA_W    register-file read data for rs / rt
//   id_imm         in   DATA_W    sign-extended immediate
//   id_alusrc      in   1         1: operand2 = immediate
//   id_uses_rt     in   1         instruction reads rt (R-type, store, branch)
//   id_aluop       in   4         ALU control code
//   id_regwrite, id_memread, id_memwrite  in 1 each  control bits
//   flush          in   1         branch taken: kill the decode-slot instruction
//   exmem_regwrite in 1; exmem_rd in REG_AW; exmem_result in DATA_W   EX/MEM forward source
//   memwb_regwrite in 1; memwb_rd in REG_AW; memwb_result in DATA_W   MEM/WB forward source
//   operand1, operand2  out DATA_W  ALU operands (combinational from regs + forward muxes)
//   ALUOP          out  4         ALU control code to ALU
//   ex_valid, ex_regwrite, ex_memread, ex_memwrite  out 1 each  registered control
//   ex_rd          out  REG_AW    registered destination
//   ex_store_data  out  DATA_W    forwarded rt value for stores
//   stall          out  1         combinational; hold PC and IF/ID this cycle
//   stall_count    out  STALL_CW  saturating count of load-use stall cycles
// BEHAVIOUR
//   - Reset: all registered fields 0 (ex_valid=0, ALUOP=4'b0000, ex_rd=0, stall_count=0).
//     Reset is asynchronous; a mid-operation reset drops the in-flight entry, no writeback.
//   - stall = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ~flush &
//             ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
//   - Per posedge, priority order:
//       flush        -> bubble: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ALUOP cleared
//       stall        -> bubble (same as flush); upstream holds ID, which is re-presented next cycle
//       else         -> capture all id_* fields; ex_valid<=id_valid; if !id_valid, control bits 0
//   - Bubble data fields (rs, rt, rdata, imm) may hold stale values; control bits must be 0.
//   - Forwarding (combinational on registered rs/rt), per source operand:
//       exmem_regwrite & exmem_rd!=0 & exmem_rd==src  -> exmem_result (highest priority)
//       else memwb_regwrite & memwb_rd!=0 & memwb_rd==src -> memwb_result
//       else registered rdata. Register 0 is never forwarded.
//   - operand1 = fwd(rs); operand2 = alusrc ? imm : fwd(rt); ex_store_data = fwd(rt) always.
//   - Latency: one cycle ID->EX; forward path zero-cycle (same-cycle combinational).
//   - stall_count += 1 on each cycle stall=1; saturates at all-ones, never wraps.
//   - Simultaneous flush & load-use condition: flush wins; stall=0; counter unchanged.
// TESTING
//   1 Reset asserted mid-stream with ex_valid=1 -> all outputs 0 immediately, stall=0, count=0.
//   2 EX/MEM rd=5 result=0x11, MEM/WB rd=5 result=0x22, ID rs=5 -> operand1=0x11 (EX/MEM wins).
//   3 lw rd=8 in EX, next ID add rs=8 -> stall=1 one cycle, bubble; then add issues with MEM/WB fwd.
//   4 lw rd=0 in EX, ID rs=0 -> no stall; exmem_rd=0 regwrite=1 -> operand1 = rdata1, not forwarded.
//   5 flush=1 while load-use condition true -> stall=0, ex_valid=0 next cycle, count unchanged.
//   6 STALL_CW=2, 5 consecutive load-use stalls -> stall_count = 3 (saturated), no wrap.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use stall
// detection with bubble insertion, branch flush, and a saturating stall-cycle counter.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [DATA_W-1:0]   id_rdata1,
  input  logic [DATA_W-1:0]   id_rdata2,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                id_alusrc,
  input  logic                id_uses_rt,
  input  logic [3:0]          id_aluop,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                flush,
  input  logic                exmem_regwrite,
  input  logic [REG_AW-1:0]   exmem_rd,
  input  logic [DATA_W-1:0]   exmem_result,
  input  logic                memwb_regwrite,
  input  logic [REG_AW-1:0]   memwb_rd,
  input  logic [DATA_W-1:0]   memwb_result,
  output logic [DATA_W-1:0]   operand1,
  output logic [DATA_W-1:0]   operand2,
  output logic [3:0]          ALUOP,
  output logic                ex_valid,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [DATA_W-1:0]   ex_store_data,
  output logic                stall,
  output logic [STALL_CW-1:0] stall_count
);

  logic                ex_valid_q, ex_valid_d;
  logic                ex_regwrite_q, ex_regwrite_d;
  logic                ex_memread_q, ex_memread_d;
  logic                ex_memwrite_q, ex_memwrite_d;
  logic                alusrc_q, alusrc_d;
  logic [3:0]          aluop_q, aluop_d;
  logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0]   rs_q, rs_d;
  logic [REG_AW-1:0]   rt_q, rt_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [STALL_CW-1:0] stall_count_q, stall_count_d;
  logic [DATA_W-1:0]   fwd_rs, fwd_rt;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  always_comb begin
    stall = ex_valid_q & ex_memread_q & (ex_rd_q != '0) & id_valid & ~flush &
            ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    alusrc_d      = alusrc_q;
    aluop_d       = aluop_q;
    ex_rd_d       = ex_rd_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rdata1_d      = rdata1_q;
    rdata2_d      = rdata2_q;
    imm_d         = imm_q;
    if (flush || stall) begin
      // Bubble: only control is cleared, data fields are don't-care.
      ex_valid_d    = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_memwrite_d = 1'b0;
      aluop_d       = 4'b0000;
    end else begin
      ex_valid_d    = id_valid;
      ex_regwrite_d = id_valid & id_regwrite;
      ex_memread_d  = id_valid & id_memread;
      ex_memwrite_d = id_valid & id_memwrite;
      aluop_d       = id_valid ? id_aluop : 4'b0000;
      alusrc_d      = id_alusrc;
      ex_rd_d       = id_rd;
      rs_d          = id_rs;
      rt_d          = id_rt;
      rdata1_d      = id_rdata1;
      rdata2_d      = id_rdata2;
      imm_d         = id_imm;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + {{(STALL_CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      alusrc_q      <= 1'b0;
      aluop_q       <= 4'b0000;
      ex_rd_q       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      imm_q         <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      alusrc_q      <= alusrc_d;
      aluop_q       <= aluop_d;
      ex_rd_q       <= ex_rd_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      imm_q         <= imm_d;
      stall_count_q <= stall_count_d;
    end
  end

  // EX/MEM is the younger producer, so it takes priority over MEM/WB.
  always_comb begin
    fwd_rs = rdata1_q;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rdata2_q;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_rt = memwb_result;
    end
  end

  assign operand1      = fwd_rs;
  assign operand2      = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUOP         = aluop_q;
  assign ex_valid      = ex_valid_q;
  assign ex_regwrite   = ex_regwrite_q;
  assign ex_memread    = ex_memread_q;
  assign ex_memwrite   = ex_memwrite_q;
  assign ex_rd         = ex_rd_q;
  assign stall_count   = stall_count_q;

endmodule
